// File: rtl/udiv32_sequencer_if.sv
// udiv32_sequencer_if: operand/result handshake bundle between an issuing master and the divider.
interface udiv32_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        busy;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/udiv32_sequencer.sv
// udiv32_sequencer: iterative restoring unsigned divider, one quotient bit per clock over 32 clocks.
module udiv32_sequencer #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    udiv32_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] r, q, n, d, r_in, r_out, q_out;
    logic [4:0]       cnt;
    logic             dz, busy, out_valid, ge, accept;
    // Restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        r_in   = {r[WIDTH-2:0], n[WIDTH-1]};
        ge     = r_in >= d;
        r_out  = ge ? r_in - d : r_in;
        q_out  = {q[WIDTH-2:0], ge};
        accept = bus.in_valid && bus.in_ready;
    end
    assign bus.in_ready    = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.busy        = busy;
    assign bus.out_valid   = out_valid;
    assign bus.quotient    = q;
    assign bus.remainder   = r;
    assign bus.div_by_zero = dz;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            q         <= '0;
            n         <= '0;
            d         <= '0;
            cnt       <= '0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else if (state == RUN) begin
            r   <= r_out;
            q   <= q_out;
            n   <= {n[WIDTH-2:0], 1'b0};
            cnt <= cnt + 5'd1;
            if (cnt == 5'(WIDTH - 1)) begin
                state     <= DONE;
                busy      <= 1'b0;
                out_valid <= 1'b1;
            end
        end else if (accept) begin
            state     <= RUN;
            n         <= bus.dividend;
            d         <= bus.divisor;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            dz        <= bus.divisor == '0;
            busy      <= 1'b1;
            out_valid <= 1'b0;
        end else if (state == DONE && bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_udiv32_sequencer.sv
// tb_udiv32_sequencer: directed tests of the iterative divider with hand-computed results.
module tb_udiv32_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    udiv32_sequencer_if bus ();
    udiv32_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] nv, input logic [31:0] dv);
        bus.in_valid = 1'b1;
        bus.dividend = nv;
        bus.divisor  = dv;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.dividend = '0;
        bus.divisor = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero); end
        checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
    endtask

    task automatic test_basic();
        int cyc;
        bus.out_ready = 1'b1;
        start_op(32'd100, 32'd7);
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_run busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready); end
        wait_done(cyc);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL basic_latency got %0d want 32", cyc); end
        checks++; if (bus.quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient got %0d want 14", bus.quotient); end
        checks++; if (bus.remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder got %0d want 2", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", bus.div_by_zero); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", bus.busy); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_large_divisor();
        int cyc;
        start_op(32'hFFFF_FFFF, 32'h8000_0000);
        wait_done(cyc);
        checks++; if (bus.quotient !== 32'd1) begin errors++; $display("FAIL large1_quotient got %h want 1", bus.quotient); end
        checks++; if (bus.remainder !== 32'h7FFF_FFFF) begin errors++; $display("FAIL large1_remainder got %h want 7fffffff", bus.remainder); end
        tick();
        start_op(32'd5, 32'hFFFF_FFFF);
        wait_done(cyc);
        checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL large2_quotient got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'd5) begin errors++; $display("FAIL large2_remainder got %h want 5", bus.remainder); end
        tick();
    endtask

    task automatic test_div_by_zero();
        int cyc;
        start_op(32'd1234, 32'd0);
        wait_done(cyc);
        checks++; if (bus.quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient got %h want ffffffff", bus.quotient); end
        checks++; if (bus.remainder !== 32'd1234) begin errors++; $display("FAIL dz_remainder got %0d want 1234", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", bus.div_by_zero); end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        bus.out_ready = 1'b0;
        start_op(32'd1000, 32'd3);
        repeat (5) tick();
        bus.in_valid = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor = 32'd5;
        tick();
        bus.in_valid = 1'b0;
        wait_done(cyc);
        checks++; if (cyc !== 26) begin errors++; $display("FAIL bp_latency got %0d want 26", cyc); end
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 32'd333 || bus.remainder !== 32'd1) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d want 0 (q=%0d r=%0d)", bad, bus.quotient, bus.remainder); end
        checks++; if (bus.quotient !== 32'd333 || bus.remainder !== 32'd1) begin errors++; $display("FAIL bp_result got %0d r %0d want 333 r 1", bus.quotient, bus.remainder); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_follows got %b want 1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release out_valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] nv [4] = '{32'd1000000, 32'hDEAD_BEEF, 32'd12345, 32'd7};
        logic [31:0] dv [4] = '{32'd1000, 32'd16, 32'd100, 32'd0};
        int cyc;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.dividend = nv[0];
        bus.divisor = dv[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                bus.dividend = nv[i+1];
                bus.divisor = dv[i+1];
            end else bus.in_valid = 1'b0;
            wait_done(cyc);
            checks++; if (cyc !== 32) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 32", i, cyc); end
            checks++; if (bus.quotient !== (dv[i] == 0 ? 32'hFFFF_FFFF : nv[i] / dv[i])) begin errors++; $display("FAIL b2b_quotient[%0d] got %h", i, bus.quotient); end
            checks++; if (bus.remainder !== (dv[i] == 0 ? nv[i] : nv[i] % dv[i])) begin errors++; $display("FAIL b2b_remainder[%0d] got %h", i, bus.remainder); end
            checks++; if (bus.div_by_zero !== (dv[i] == 0)) begin errors++; $display("FAIL b2b_dz[%0d] got %b", i, bus.div_by_zero); end
            tick();
            if (i < 3) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_idle[%0d] busy got %b want 1", i, bus.busy); end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        int seen = 0;
        start_op(32'h0000_FFFF, 32'd3);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctrl busy=%b out_valid=%b in_ready=%b want 0/0/1", bus.busy, bus.out_valid, bus.in_ready); end
        checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL rstmid_outputs q=%h r=%h dz=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero); end
        repeat (40) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_pulse out_valid cycles=%0d want 0", seen); end
        start_op(32'd81, 32'd9);
        wait_done(cyc);
        checks++; if (cyc !== 32) begin errors++; $display("FAIL rstmid_latency got %0d want 32", cyc); end
        checks++; if (bus.quotient !== 32'd9 || bus.remainder !== 32'd0) begin errors++; $display("FAIL rstmid_result got %0d r %0d want 9 r 0", bus.quotient, bus.remainder); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large_divisor();
        test_div_by_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
